// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Registered, parametrised bitwise logic unit. It applies one of eight bitwise
//   operations to WIDTH-bit operands and presents the result through a single
//   output register with valid/ready handshakes on both sides. In accumulate
//   mode the second operand is the previous result instead of b.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//   CNT_W      width of the saturating accepted-transaction counter (>= 1)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   a/b/op/acc_en carry a transaction this cycle
//   in_ready   unit can accept a transaction this cycle
//   a, b       operands (b is ignored when acc_en = 1)
//   op         operation select:
//                0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOTA, 7 PASSA
//   acc_en     1: second operand is the accumulator instead of b
//   out_valid  y/y_zero/y_parity hold a valid result
//   out_ready  consumer takes the result this cycle
//   y          registered result
//   y_zero     y == 0, registered with y
//   y_parity   XOR reduction of y, registered with y
//   op_count   number of accepted transactions, saturating
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             y_parity,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [2:0] {
      OpAnd   = 3'd0,
      OpOr    = 3'd1,
      OpNand  = 3'd2,
      OpNor   = 3'd3,
      OpXor   = 3'd4,
      OpXnor  = 3'd5,
      OpNota  = 3'd6,
      OpPassa = 3'd7
   } op_e;

   // Registered state
   logic [WIDTH-1:0] y_q;
   logic             zero_q;
   logic             parity_q;
   logic             valid_q;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;

   // Combinational datapath
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] result;
   logic             accept;
   logic             transfer;
   logic             cnt_sat;

   // The output register frees up either when empty or when it drains this
   // cycle, which gives full back-to-back throughput with a single stage.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign transfer = valid_q && out_ready;
   assign cnt_sat  = (cnt_q == {CNT_W{1'b1}});

   always_comb begin
      opnd_b = acc_en ? acc_q : b;
      result = '0;
      case (op_e'(op))
         OpAnd:   result = a & opnd_b;
         OpOr:    result = a | opnd_b;
         OpNand:  result = ~(a & opnd_b);
         OpNor:   result = ~(a | opnd_b);
         OpXor:   result = a ^ opnd_b;
         OpXnor:  result = ~(a ^ opnd_b);
         OpNota:  result = ~a;
         OpPassa: result = a;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q      <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         valid_q  <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            y_q      <= result;
            zero_q   <= (result == '0);
            parity_q <= ^result;
            // acc follows every accepted result, whichever operand was used.
            acc_q    <= result;
         end

         // A simultaneous transfer and accept keeps the register full.
         if (accept) begin
            valid_q <= 1'b1;
         end else if (transfer) begin
            valid_q <= 1'b0;
         end

         if (accept && !cnt_sat) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_valid = valid_q;
   assign y         = y_q;
   assign y_zero    = zero_q;
   assign y_parity  = parity_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Directed and randomised bench for logic_unit_pipe (WIDTH=8, CNT_W=8).
//   Inputs change 1 time unit after the rising edge; a negedge monitor keeps a
//   scoreboard of expected results and checks every output transfer, in_ready,
//   out_valid and op_count against a small reference model.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

   typedef struct packed {
      logic [7:0] y;
      logic       zero;
      logic       parity;
   } res_t;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       acc_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       y_zero;
   logic       y_parity;
   logic [7:0] op_count;

   int n_cmp = 0;
   int n_err = 0;

   res_t       sb_q[$];
   logic [7:0] m_acc;
   logic [7:0] m_cnt;
   logic       mon_en = 1'b0;

   logic_unit_pipe #(
      .WIDTH(8),
      .CNT_W(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .op       (op),
      .acc_en   (acc_en),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y),
      .y_zero   (y_zero),
      .y_parity (y_parity),
      .op_count (op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] z);
      case (o)
         3'd0:    return x & z;
         3'd1:    return x | z;
         3'd2:    return ~(x & z);
         3'd3:    return ~(x | z);
         3'd4:    return x ^ z;
         3'd5:    return ~(x ^ z);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: check outputs against the model, then advance the
   // model to what the coming rising edge should do.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
         chk("in_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() == 0) || out_ready});
         chk("op_count", {24'd0, op_count}, {24'd0, m_cnt});
         if (sb_q.size() != 0 && out_valid) begin
            chk("sb_y", {24'd0, y}, {24'd0, sb_q[0].y});
            chk("sb_zero", {31'd0, y_zero}, {31'd0, sb_q[0].zero});
            chk("sb_parity", {31'd0, y_parity}, {31'd0, sb_q[0].parity});
         end
      end
      if (reset) begin
         sb_q.delete();
         m_acc = 8'h00;
         m_cnt = 8'h00;
      end else begin
         logic   acc_now;
         logic [7:0] r;
         acc_now = in_valid && ((sb_q.size() == 0) || out_ready);
         if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
         if (acc_now) begin
            r = ref_op(op, a, acc_en ? m_acc : b);
            sb_q.push_back('{y: r, zero: (r == 8'h00), parity: ^r});
            m_acc = r;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         end
      end
   end

   initial begin
      logic [7:0] tt_exp[8];
      logic       pending;
      tt_exp = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

      reset     = 1'b1;
      in_valid  = 1'b1;
      a         = 8'h00;
      b         = 8'h00;
      op        = 3'd0;
      acc_en    = 1'b0;
      out_ready = 1'b1;
      m_acc     = 8'h00;
      m_cnt     = 8'h00;
      tick();
      mon_en = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_y", {24'd0, y}, 32'd0);
      chk("rst_y_zero", {31'd0, y_zero}, 32'd0);
      chk("rst_y_parity", {31'd0, y_parity}, 32'd0);
      chk("rst_op_count", {24'd0, op_count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1. Truth table
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         a        = 8'hF0;
         b        = 8'hCC;
         op       = 3'(i);
         acc_en   = 1'b0;
         tick();
         chk($sformatf("tt_y_op%0d", i), {24'd0, y}, {24'd0, tt_exp[i]});
         chk($sformatf("tt_par_op%0d", i), {31'd0, y_parity}, 32'd0);
      end
      in_valid = 1'b0;
      chk("tt_count", {24'd0, op_count}, 32'd8);
      tick();

      // 2. Stall
      in_valid  = 1'b1;
      op        = 3'd4;
      a         = 8'hAA;
      b         = 8'h55;
      out_ready = 1'b0;
      tick();
      chk("stall_y", {24'd0, y}, 32'hFF);
      chk("stall_zero", {31'd0, y_zero}, 32'd0);
      chk("stall_parity", {31'd0, y_parity}, 32'd0);
      op = 3'd0;
      a  = 8'h0F;
      b  = 8'h33;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold_y", {24'd0, y}, 32'hFF);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_count", {24'd0, op_count}, 32'd9);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("release_new_y", {24'd0, y}, 32'h03);
      chk("release_count", {24'd0, op_count}, 32'd10);
      in_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // 3. Accumulate
      in_valid = 1'b1;
      op = 3'd7; a = 8'h0F; b = 8'hAA; acc_en = 1'b0;
      tick();
      chk("acc_passa", {24'd0, y}, 32'h0F);
      op = 3'd4; a = 8'hFF; b = 8'h00; acc_en = 1'b1;
      tick();
      chk("acc_xor", {24'd0, y}, 32'hF0);
      op = 3'd0; a = 8'h3C; b = 8'hFF;
      tick();
      chk("acc_and", {24'd0, y}, 32'h30);
      chk("acc_and_par", {31'd0, y_parity}, 32'd0);
      op = 3'd3; a = 8'hCF;
      tick();
      chk("acc_nor", {24'd0, y}, 32'h00);
      chk("acc_nor_zero", {31'd0, y_zero}, 32'd1);
      in_valid = 1'b0;
      acc_en   = 1'b0;
      tick();

      // 4. Saturation
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op     = 3'($urandom_range(0, 7));
         a      = 8'($urandom);
         b      = 8'($urandom);
         acc_en = 1'($urandom_range(0, 1));
         tick();
      end
      chk("sat_count", {24'd0, op_count}, 32'hFF);
      tick();
      chk("sat_hold", {24'd0, op_count}, 32'hFF);
      in_valid = 1'b0;
      acc_en   = 1'b0;
      tick();

      // 5. Reset mid-stall
      in_valid  = 1'b1;
      op        = 3'd5;
      a         = 8'h12;
      b         = 8'h34;
      out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_y", {24'd0, y}, 32'd0);
      chk("mid_rst_count", {24'd0, op_count}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = 3'd1; a = 8'h01; b = 8'hF0; acc_en = 1'b1;
      tick();
      chk("post_rst_acc", {24'd0, y}, 32'h01);
      in_valid = 1'b0;
      acc_en   = 1'b0;
      tick();

      // 6. Random traffic; the source holds a pending transaction until taken
      pending = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (!pending) begin
            in_valid = 1'($urandom_range(0, 1));
            op       = 3'($urandom_range(0, 7));
            a        = 8'($urandom);
            b        = 8'($urandom);
            acc_en   = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #2;
         pending = in_valid && !in_ready;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("final_sb_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
